grid_scan: RTL and testbench

Display-side reader of the 64-bit Game of Life `grid` bus. Snapshots the grid on a frame boundary and row-scans it onto an 8x8 LED matrix through two daisy-chained serial-in/parallel-out shift registers (row-select byte plus column byte). Sits between the top-level `grid` output and the board pins. The snapshot keeps evolution and display decoupled, so a generation update never tears a frame.

---
 rtl/grid_scan_pkg.sv | 27 ++
 rtl/grid_scan_if.sv | 17 +
 rtl/grid_row_shifter.sv | 64 ++++++
 rtl/grid_scan.sv | 102 ++++++++++
 tb/tb_grid_scan.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_scan_pkg.sv
// Shared types and constants for the grid_scan LED matrix scanner.
// Row r of the grid occupies bits [63-8r -: 8], with column 0 as the MSB of that byte.
package grid_scan_pkg;

  localparam int GRID_W = 64;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    DWELL
  } state_t;

  function automatic logic [COLS-1:0] grid_row(logic [GRID_W-1:0] g, logic [2:0] row);
    return g[(ROWS - 1 - int'(row)) * COLS +: COLS];
  endfunction

  // Row-select byte goes out first, so it lands in the far shift register.
  function automatic logic [WORD_W-1:0] build_word(logic [2:0] row, logic [COLS-1:0] cols);
    return {8'h80 >> row, cols};
  endfunction

endpackage

// File: rtl/grid_scan_if.sv
// Grid input bus and LED-matrix pin group for grid_scan.
// The scanner takes the slave side; the grid producer and board pins take the master side.
interface grid_scan_if;
  import grid_scan_pkg::*;

  logic [GRID_W-1:0] grid;
  logic              grid_valid;
  logic              sclk;
  logic              sdata;
  logic              rclk;
  logic              oe_n;

  modport master (output grid, output grid_valid,
                  input sclk, input sdata, input rclk, input oe_n);
  modport slave  (input grid, input grid_valid,
                  output sclk, output sdata, output rclk, output oe_n);
endinterface

// File: rtl/grid_row_shifter.sv
// 16-bit parallel-in/serial-out shifter with a CLK_DIV sclk divider.
// Sends the MSB first; sdata only moves on the cycle sclk falls.
module grid_row_shifter
  import grid_scan_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              sclk,
  output logic              sdata,
  output logic              done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]     div_cnt;
  logic [3:0]        bit_cnt;
  logic [WORD_W-1:0] sr;
  logic              active;
  logic              phase_end;

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  assign done      = active && sclk && phase_end && (bit_cnt == 4'(WORD_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else if (load) begin
      sr      <= {word[WORD_W-2:0], 1'b0};
      sdata   <= word[WORD_W-1];
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (!phase_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          // Falling edge: present the next bit; a zero trails the final bit.
          sclk  <= 1'b0;
          sdata <= sr[WORD_W-1];
          sr    <= {sr[WORD_W-2:0], 1'b0};
          if (bit_cnt == 4'(WORD_W - 1))
            active <= 1'b0;
          else
            bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/grid_scan.sv
// Snapshots the Game of Life grid at each frame start and row-scans it onto an 8x8 LED matrix.
// Define GRID_SCAN_BLANK_EN to enable the LEDs only during the dwell phase of each row.
module grid_scan #(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  grid_scan_if.slave  bus,
  output logic        busy,
  output logic        frame_done
);
  import grid_scan_pkg::*;

  localparam int CNT_MAX = (DWELL > CLK_DIV) ? DWELL : CLK_DIV;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t            state, state_nxt;
  logic [2:0]        row;
  logic [CW-1:0]     cnt;
  logic [GRID_W-1:0] snapshot;
  logic              pending;
  logic              capture;
  logic              row_end;
  logic              shift_done;
  logic [COLS-1:0]   cols;
  logic [WORD_W-1:0] word;

  // Row 0 of a capturing frame takes its bits straight from the bus being captured.
  assign capture = (state == LOAD) && (row == 3'd0) && pending;
  assign cols    = capture ? grid_row(bus.grid, row) : grid_row(snapshot, row);
  assign word    = build_word(row, cols);

  grid_row_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (state == LOAD),
    .word  (word),
    .sclk  (bus.sclk),
    .sdata (bus.sdata),
    .done  (shift_done)
  );

  always_comb begin
    state_nxt  = state;
    row_end    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (shift_done) state_nxt = LATCH;
      LATCH: if (cnt == CW'(CLK_DIV - 1)) state_nxt = grid_scan_pkg::DWELL;
      grid_scan_pkg::DWELL: begin
        if (cnt == CW'(DWELL - 1)) begin
          row_end = 1'b1;
          if (row == 3'd7) begin
            frame_done = 1'b1;
            state_nxt  = en ? LOAD : IDLE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign bus.rclk = (state == LATCH);
`ifdef GRID_SCAN_BLANK_EN
  assign bus.oe_n = (state != grid_scan_pkg::DWELL);
`else
  assign bus.oe_n = (state == IDLE);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      row      <= 3'd0;
      snapshot <= '0;
      pending  <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || !((state == LATCH) || (state == grid_scan_pkg::DWELL)))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (row_end)
        row <= row + 1'b1;
      // A grid_valid arriving in the capture cycle is absorbed by that capture.
      if (capture) begin
        snapshot <= bus.grid;
        pending  <= 1'b0;
      end else if (bus.grid_valid) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grid_scan.sv
// Directed bench for grid_scan at CLK_DIV=2, DWELL=10 (77-cycle rows, 616-cycle frames).
// Row cycles are counted from 1 at the LOAD cycle of row 0.
module tb_grid_scan;
  import grid_scan_pkg::*;

  localparam logic [63:0] G1   = 64'h0038_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] GA   = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] GC   = 64'hA500_0000_0000_003C;
  localparam logic [63:0] GD   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] GE   = 64'h5AC3_0000_0000_0000;
`ifdef GRID_SCAN_BLANK_EN
  localparam int OE_LOW_EXP = 80;
`else
  localparam int OE_LOW_EXP = 616;
`endif

  typedef struct {
    logic        en;
    logic        gv;
    logic [63:0] grid;
    logic [5:0]  exp_outs;
  } rst_vec_t;

  typedef struct {
    logic [15:0] word;
    int          rclk_at;
  } row_vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b0;
  logic busy;
  logic frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  grid_scan_if bus();

  grid_scan #(.CLK_DIV(2), .DWELL(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: rebuilds shifted words from sclk rises and logs latch timing.
  logic [15:0] words[$];
  int          rclk_at[$];
  logic [15:0] cur = '0;
  int          start = 0;
  int          rclk_hi = 0;
  int          oe_low = 0;
  logic        prev_sclk = 1'b0, prev_rclk = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!prev_busy && busy) start = cyc;
    if (!prev_sclk && bus.sclk) cur = {cur[14:0], bus.sdata};
    if (!prev_rclk && bus.rclk) begin
      words.push_back(cur);
      rclk_at.push_back(cyc - start + 1);
    end
    if (bus.rclk) rclk_hi++;
    if (!bus.oe_n) oe_low++;
    prev_sclk = bus.sclk;
    prev_rclk = bus.rclk;
    prev_busy = busy;
  end

  function automatic logic [5:0] outs();
    return {bus.sclk, bus.sdata, bus.rclk, bus.oe_n, busy, frame_done};
  endfunction

  function automatic logic [15:0] get_word(int i);
    return (words.size() > i) ? words[i] : 16'h0000;
  endfunction

  function automatic int get_at(int i);
    return (rclk_at.size() > i) ? rclk_at[i] : -1;
  endfunction

  task automatic clear_mon();
    words.delete();
    rclk_at.delete();
    rclk_hi = 0;
    oe_low  = 0;
  endtask

  task automatic apply_stimulus(input logic e, input logic gv, input logic [63:0] g);
    @(posedge clk);
    #1;
    en             = e;
    bus.grid_valid = gv;
    bus.grid       = g;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame_done(input int limit, output int rel);
    bit seen = 0;
    rel = -1;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (frame_done) begin
        rel  = cyc - start + 1;
        seen = 1;
      end
    end
  endtask

  task automatic wait_words(input int count, input int limit);
    for (int n = 0; n < limit && words.size() < count; n++) @(negedge clk);
  endtask

  rst_vec_t rst_tab[4];
  row_vec_t frame_tab[8];

  initial begin
    int rel;
    logic [15:0] exp_w;

    rst_tab[0] = '{1'b1, 1'b0, 64'h0,  6'b000100};
    rst_tab[1] = '{1'b1, 1'b1, ONES,   6'b000100};
    rst_tab[2] = '{1'b0, 1'b1, GD,     6'b000100};
    rst_tab[3] = '{1'b1, 1'b1, GA,     6'b000100};

    frame_tab[0] = '{16'h8000,  66};
    frame_tab[1] = '{16'h4038, 143};
    frame_tab[2] = '{16'h2000, 220};
    frame_tab[3] = '{16'h1000, 297};
    frame_tab[4] = '{16'h0800, 374};
    frame_tab[5] = '{16'h0400, 451};
    frame_tab[6] = '{16'h0200, 528};
    frame_tab[7] = '{16'h0100, 605};

    bus.grid       = '0;
    bus.grid_valid = 1'b0;

    // Reset held: inputs toggle, outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(rst_tab[i].en, rst_tab[i].gv, rst_tab[i].grid);
      @(negedge clk);
      check_output($sformatf("reset_vec%0d", i), outs(), rst_tab[i].exp_outs);
    end
    apply_stimulus(1'b0, 1'b0, G1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_outs", outs(), 6'b000100);

    // Single frame with a one-cycle enable.
    clear_mon();
    apply_stimulus(1'b1, 1'b0, G1);
    apply_stimulus(1'b0, 1'b0, G1);
    @(negedge clk);
    check_output("busy_in_load", busy, 1'b1);
    wait_frame_done(700, rel);
    check_output("frame1_done_cycle", rel, 616);
    @(negedge clk);
    check_output("frame1_idle", {busy, frame_done}, 2'b00);
    for (int r = 0; r < 8; r++) begin
      check_output($sformatf("frame1_word_row%0d", r), get_word(r), frame_tab[r].word);
      check_output($sformatf("frame1_rclk_row%0d", r), get_at(r), frame_tab[r].rclk_at);
    end
    check_output("frame1_rclk_high_cycles", rclk_hi, 16);
    check_output("frame1_oe_low_cycles", oe_low, OE_LOW_EXP);

    // New generation during row 3: current frame keeps the old snapshot.
    clear_mon();
    apply_stimulus(1'b1, 1'b0, G1);
    repeat (250) @(negedge clk);
    apply_stimulus(1'b1, 1'b1, ONES);
    apply_stimulus(1'b1, 1'b0, ONES);
    wait_frame_done(700, rel);
    check_output("frame2_done_cycle", rel, 616);
    wait_words(9, 200);
    apply_stimulus(1'b0, 1'b0, ONES);
    wait_frame_done(700, rel);
    check_output("frame3_done_cycle", rel, 1232);
    @(negedge clk);
    check_output("frame3_idle_busy", busy, 1'b0);
    for (int r = 3; r < 8; r++)
      check_output($sformatf("frame2_old_row%0d", r), get_word(r), frame_tab[r].word);
    check_output("frame3_no_gap_rclk", get_at(8), 682);
    for (int r = 0; r < 8; r++) begin
      exp_w = {8'h80 >> r, 8'hFF};
      check_output($sformatf("frame3_word_row%0d", r), get_word(8 + r), exp_w);
    end

    // grid_valid in the capture cycle: that grid is taken and pending ends cleared.
    clear_mon();
    apply_stimulus(1'b1, 1'b1, GA);
    apply_stimulus(1'b0, 1'b1, GC);
    apply_stimulus(1'b0, 1'b0, GD);
    wait_frame_done(700, rel);
    @(negedge clk);
    check_output("simul_row0", get_word(0), 16'h80A5);
    check_output("simul_row7", get_word(7), 16'h013C);
    clear_mon();
    apply_stimulus(1'b1, 1'b0, GD);
    apply_stimulus(1'b0, 1'b0, GD);
    wait_frame_done(700, rel);
    @(negedge clk);
    check_output("reuse_row0", get_word(0), 16'h80A5);
    check_output("reuse_row7", get_word(7), 16'h013C);

    // Reset at bit 9 of row 5, then restart with a fresh capture.
    clear_mon();
    apply_stimulus(1'b1, 1'b0, GD);
    repeat (423) @(negedge clk);
    check_output("pre_reset_busy_sclk", {busy, bus.sclk}, 2'b11);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_output("async_reset_outs", outs(), 6'b000100);
    bus.grid = GE;
    repeat (3) @(negedge clk);
    clear_mon();
    reset = 1'b1;
    wait_words(2, 300);
    apply_stimulus(1'b0, 1'b0, GE);
    wait_frame_done(700, rel);
    check_output("restart_done_cycle", rel, 616);
    @(negedge clk);
    check_output("restart_row0", get_word(0), 16'h805A);
    check_output("restart_row1", get_word(1), 16'h40C3);
    check_output("restart_rclk_row0", get_at(0), 66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
